// File: rtl/uart_tx_arbiter_if.sv
// Requester-side bundle of uart_tx_arbiter: request/byte inputs and grant/load outputs.
// Latency: none (wires only).
// Backpressure: requesters hold req/din until ack; busy reports the arbiter is mid-frame.
interface uart_tx_arbiter_if;
    logic [3:0]  req;
    logic [31:0] din;
    logic [3:0]  ack;
    logic        load;
    logic [7:0]  d;
    logic        busy;
    logic [1:0]  grant_id;

    // Client side: presents requests, observes grants.
    modport master (
        output req, din,
        input  ack, load, d, busy, grant_id
    );

    // Arbiter side.
    modport slave (
        input  req, din,
        output ack, load, d, busy, grant_id
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Purpose: shares one uart_tx among four byte requesters (round-robin, or fixed priority
//          when UART_ARB_FIXED_PRIO_EN is defined); times each frame itself since uart_tx has no done.
// Latency: req sampled in IDLE at cycle n -> load/ack at n+1; load spacing T + GAP_CLKS + 2.
// Backpressure: requests are only sampled in IDLE; busy stays high from load until back in IDLE.
module uart_tx_arbiter #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int FRAME_BITS   = 10,
    parameter int LOAD_LAT     = 2,
    parameter int GAP_CLKS     = 0
) (
    input  logic             clk,
    input  logic             reset,
    uart_tx_arbiter_if.slave arb
);

    // Cycles spent in WAIT: uart_tx load delay plus the full serialised frame.
    localparam int T  = LOAD_LAT + CLKS_PER_BIT * FRAME_BITS;
    localparam int CW = (T > 1) ? $clog2(T) : 1;
    localparam int GW = (GAP_CLKS > 0) ? $clog2(GAP_CLKS + 1) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(T - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CLKS > 0) ? (GAP_CLKS - 1) : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_WAIT = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic [GW-1:0] gcnt_q, gcnt_d;
    logic [3:0]    ack_q, ack_d;
    logic          load_q, load_d;
    logic [7:0]    d_q, d_d;
    logic          busy_q, busy_d;
    logic [1:0]    gid_q, gid_d;

    logic [1:0]    winner;
    logic          win_vld;
`ifndef UART_ARB_FIXED_PRIO_EN
    logic [1:0]    idx;
`endif

    // Winner pick: first set req searching upward from the requester after the last grant
    // (grant_id doubles as the rr pointer), or the lowest set bit in fixed-priority builds.
    always_comb begin
        winner  = 2'd0;
        win_vld = 1'b0;
`ifdef UART_ARB_FIXED_PRIO_EN
        for (int k = 3; k >= 0; k--) begin
            if (arb.req[k]) begin
                winner  = 2'(k);
                win_vld = 1'b1;
            end
        end
`else
        idx = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx = gid_q + 2'(k + 1);
            if (!win_vld && arb.req[idx]) begin
                winner  = idx;
                win_vld = 1'b1;
            end
        end
`endif
    end

    // Next-state and registered-output decode.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        gcnt_d  = gcnt_q;
        ack_d   = 4'b0000;
        d_d     = d_q;
        gid_d   = gid_q;
        case (state_q)
            S_IDLE: begin
                if (win_vld) begin
                    state_d = S_LOAD;
                    d_d     = arb.din[{winner, 3'b000} +: 8];
                    gid_d   = winner;
                    ack_d   = 4'b0001 << winner;
                end
            end
            S_LOAD: begin
                state_d = S_WAIT;
                wcnt_d  = '0;
            end
            S_WAIT: begin
                if (wcnt_q == WAIT_LAST) begin
                    wcnt_d = '0;
                    if (GAP_CLKS > 0) begin
                        state_d = S_GAP;
                        gcnt_d  = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (gcnt_q == GAP_LAST) begin
                    gcnt_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    gcnt_d = gcnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Outputs are registered versions of the state being entered, so they line up with it.
        load_d = (state_d == S_LOAD);
        busy_d = (state_d != S_IDLE);
    end

    // State, counters and outputs; reset aborts any frame in flight alongside uart_tx.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
            gcnt_q  <= '0;
            ack_q   <= 4'b0000;
            load_q  <= 1'b0;
            d_q     <= 8'h00;
            busy_q  <= 1'b0;
            gid_q   <= 2'd3;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            gcnt_q  <= gcnt_d;
            ack_q   <= ack_d;
            load_q  <= load_d;
            d_q     <= d_d;
            busy_q  <= busy_d;
            gid_q   <= gid_d;
        end
    end

    assign arb.ack      = ack_q;
    assign arb.load     = load_q;
    assign arb.d        = d_q;
    assign arb.busy     = busy_q;
    assign arb.grant_id = gid_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: CLKS_PER_BIT=4, T=42; one instance with a 2-cycle gap
// (load spacing 46) and one with no gap (load spacing 44). Fixed-priority expectations apply
// when UART_ARB_FIXED_PRIO_EN is defined.
module tb_uart_tx_arbiter;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_arbiter_if ifa ();
    uart_tx_arbiter_if ifb ();

    uart_tx_arbiter #(.CLKS_PER_BIT(4), .FRAME_BITS(10), .LOAD_LAT(2), .GAP_CLKS(2)) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .arb   (ifa)
    );

    uart_tx_arbiter #(.CLKS_PER_BIT(4), .FRAME_BITS(10), .LOAD_LAT(2), .GAP_CLKS(0)) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .arb   (ifb)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until instance A pulses load, at most limit cycles.
    task automatic wait_load_a(input int limit, input string tag, output int at);
        bit ok;
        ok = 1'b0;
        at = -1;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (ifa.load) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
        end
        if (!ok) check_val({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_idle_a(input int limit, input string tag);
        bit ok;
        ok = !ifa.busy;
        for (int i = 0; i < limit && !ok; i++) begin
            tick();
            if (!ifa.busy) ok = 1'b1;
        end
        if (!ok) check_val({tag, "_idle_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        int at, prev, bn, extra, ack2, t0, exp_id, nl, lows;
        int lt [3];
        logic [7:0] bytes_t2 [4];
        logic [1:0] exp_t5 [3];
        bytes_t2 = '{8'h11, 8'h22, 8'h33, 8'h44};
`ifdef UART_ARB_FIXED_PRIO_EN
        exp_t5 = '{2'd1, 2'd1, 2'd1};
`else
        exp_t5 = '{2'd3, 2'd1, 2'd3};
`endif

        ifa.req = 4'b0000; ifa.din = 32'h0;
        ifb.req = 4'b0000; ifb.din = 32'h0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        check_val("rst_ack",   {28'h0, ifa.ack}, 32'h0);
        check_val("rst_load",  {31'h0, ifa.load}, 32'h0);
        check_val("rst_d",     {24'h0, ifa.d}, 32'h0);
        check_val("rst_busy",  {31'h0, ifa.busy}, 32'h0);
        check_val("rst_gid",   {30'h0, ifa.grant_id}, 32'd3);
        reset = 1'b0;

        // 1: single request, latency and busy length
        ifa.req = 4'b0001; ifa.din = 32'h000000A5;
        t0 = cyc;
        tick();
        check_val("t1_latency", cyc - t0, 1);
        check_val("t1_load",   {31'h0, ifa.load}, 32'h1);
        check_val("t1_ack",    {28'h0, ifa.ack}, 32'h1);
        check_val("t1_d",      {24'h0, ifa.d}, 32'hA5);
        check_val("t1_gid",    {30'h0, ifa.grant_id}, 32'd0);
        check_val("t1_busy",   {31'h0, ifa.busy}, 32'h1);
        ifa.req = 4'b0000;
        bn = 1; extra = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (i == 0) begin
                check_val("t1_ack_pulse",  {28'h0, ifa.ack}, 32'h0);
                check_val("t1_load_pulse", {31'h0, ifa.load}, 32'h0);
            end
            if (!ifa.busy) break;
            bn++;
            if (ifa.load) extra++;
        end
        check_val("t1_busy_len", bn, 45);
        check_val("t1_one_load", extra, 0);
        check_val("t1_d_hold", {24'h0, ifa.d}, 32'hA5);

        // 2: all four requesting, rotation and spacing
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ifa.din = 32'h44332211;
        ifa.req = 4'b1111;
        prev = -1;
        for (int g = 0; g < 5; g++) begin
`ifdef UART_ARB_FIXED_PRIO_EN
            exp_id = 0;
`else
            exp_id = g % 4;
`endif
            wait_load_a(60, "t2_load", at);
            check_val($sformatf("t2_gid%0d", g), {30'h0, ifa.grant_id}, exp_id);
            check_val($sformatf("t2_ack%0d", g), {28'h0, ifa.ack}, 32'h1 << exp_id);
            check_val($sformatf("t2_d%0d", g),   {24'h0, ifa.d}, {24'h0, bytes_t2[exp_id]});
            if (prev >= 0) check_val($sformatf("t2_space%0d", g), at - prev, 46);
            prev = at;
            tick();
            check_val($sformatf("t2_ackpulse%0d", g), {28'h0, ifa.ack}, 32'h0);
        end
        ifa.req = 4'b0000;
        wait_idle_a(60, "t2");

        // 3: req[2] pulsed during another grant's WAIT is ignored
        ifa.req = 4'b0001; ifa.din = 32'h00EE005A;
        wait_load_a(5, "t3_load", at);
        check_val("t3_ack", {28'h0, ifa.ack}, 32'h1);
        ifa.req = 4'b0000;
        extra = 0; ack2 = 0;
        for (int i = 0; i < 70; i++) begin
            if (i == 10) ifa.req = 4'b0100;
            if (i == 15) ifa.req = 4'b0000;
            tick();
            if (ifa.load) extra++;
            if (ifa.ack[2]) ack2++;
        end
        check_val("t3_no_load", extra, 0);
        check_val("t3_no_ack2", ack2, 0);
        check_val("t3_idle", {31'h0, ifa.busy}, 32'h0);
        check_val("t3_d_hold", {24'h0, ifa.d}, 32'h5A);

        // 4: async reset mid-WAIT, then requester 2
        ifa.req = 4'b0001; ifa.din = 32'h000000C3;
        wait_load_a(5, "t4_load", at);
        ifa.req = 4'b0000;
        repeat (10) tick();
        check_val("t4_busy_pre", {31'h0, ifa.busy}, 32'h1);
        #1 reset = 1'b1;
        #1;
        check_val("t4_rst_load", {31'h0, ifa.load}, 32'h0);
        check_val("t4_rst_ack",  {28'h0, ifa.ack}, 32'h0);
        check_val("t4_rst_busy", {31'h0, ifa.busy}, 32'h0);
        check_val("t4_rst_d",    {24'h0, ifa.d}, 32'h0);
        check_val("t4_rst_gid",  {30'h0, ifa.grant_id}, 32'd3);
        tick();
        reset = 1'b0;
        ifa.req = 4'b0100; ifa.din = 32'h005C0000;
        t0 = cyc;
        wait_load_a(5, "t4_load2", at);
        check_val("t4_latency", at - t0, 1);
        check_val("t4_ack", {28'h0, ifa.ack}, 32'h4);
        check_val("t4_gid", {30'h0, ifa.grant_id}, 32'd2);
        check_val("t4_d",   {24'h0, ifa.d}, 32'h5C);
        ifa.req = 4'b0000;
        tick();
        wait_idle_a(60, "t4");

        // 5: requesters 1 and 3 held, pointer starts after requester 2
        ifa.din = 32'h99007700;
        ifa.req = 4'b1010;
        prev = -1;
        for (int g = 0; g < 3; g++) begin
            wait_load_a(60, "t5_load", at);
            check_val($sformatf("t5_gid%0d", g), {30'h0, ifa.grant_id}, {30'h0, exp_t5[g]});
            check_val($sformatf("t5_d%0d", g), {24'h0, ifa.d}, (exp_t5[g] == 2'd1) ? 32'h77 : 32'h99);
            if (prev >= 0) check_val($sformatf("t5_space%0d", g), at - prev, 46);
            prev = at;
            tick();
        end
        ifa.req = 4'b0000;
        wait_idle_a(60, "t5");

        // 6: no-gap instance, held request
        ifb.req = 4'b0001; ifb.din = 32'h0000003C;
        nl = 0; lows = 0;
        for (int i = 0; i < 200 && nl < 3; i++) begin
            tick();
            if (ifb.load) begin
                lt[nl] = cyc;
                check_val($sformatf("t6_d%0d", nl), {24'h0, ifb.d}, 32'h3C);
                check_val($sformatf("t6_ack%0d", nl), {28'h0, ifb.ack}, 32'h1);
                nl++;
            end else if (nl > 0 && !ifb.busy) begin
                lows++;
            end
        end
        check_val("t6_loads", nl, 3);
        if (nl == 3) begin
            check_val("t6_space1", lt[1] - lt[0], 44);
            check_val("t6_space2", lt[2] - lt[1], 44);
            check_val("t6_idle_cycles", lows, 2);
        end
        ifb.req = 4'b0000;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin scheduler that shares one uart_tx instance among four byte requesters. It grants one requester at a time and issues a single-cycle load with the granted byte. Because uart_tx exposes no busy/done, the block times each frame with its own counter and blocks further loads until the frame plus an inter-frame gap has elapsed. It sits between client logic and uart_tx; its load/d outputs drive uart_tx load/d directly.

Parameters:
CLKS_PER_BIT, 5208, clk cycles per UART bit; must match the uart_tx baud divider (50 MHz / 9600).
FRAME_BITS, 10, bits per frame (start + 8 data + stop).
LOAD_LAT, 2, cycles from load to start bit inside uart_tx (load delay stage).
GAP_CLKS, 0, extra idle cycles enforced after each frame (0 = none).

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req  input  4  per-requester request; hold with din stable until ack
din  input  32  requester bytes; requester i on din[8*i+7:8*i]
ack  output  4  one-hot, 1-cycle pulse: requester's byte accepted
load  output  1  1-cycle pulse to uart_tx load
d  output  8  byte to uart_tx; registered, held stable until next grant
busy  output  1  high from load cycle until return to IDLE
grant_id  output  2  index of last granted requester

Behaviour:
- Reset (async, immediate): state=IDLE, ack=0, load=0, d=8'h00, busy=0, grant_id=2'd3, rr pointer=3 (requester 0 wins first). Counters cleared. uart_tx shares reset, so a mid-frame reset aborts both; no ack is reissued.
- States: IDLE, LOAD, WAIT, GAP.
- IDLE: sample req. If req!=0, winner = first set bit searching from (grant_id+1) mod 4 upward, wrapping. Latch d<=din[winner], grant_id<=winner, go to LOAD. If req==0, stay.
- LOAD (exactly 1 cycle): load=1, ack[winner]=1, busy=1. Go to WAIT, counter=0.
- WAIT: busy=1; lasts T = LOAD_LAT + CLKS_PER_BIT*FRAME_BITS cycles (counter 0..T-1). Then GAP if GAP_CLKS>0, else IDLE.
- GAP: busy=1; lasts GAP_CLKS cycles, then IDLE.
- Latency: req sampled high in IDLE at cycle n -> load/ack at n+1.
- Back-to-back: load-to-load spacing = T + GAP_CLKS + 2 cycles minimum.
- req changes outside IDLE are ignored; a requester dropping req before ack is withdrawn with no side effect. Requester must deassert req (or present a new byte) the cycle after ack; req still high in the next IDLE counts as a new request.
- Simultaneous requests: exactly one ack per grant; the rr pointer guarantees each continuously requesting client is served within 4 grants.
- Counter width: $clog2(T) bits (and $clog2(GAP_CLKS+1) for GAP); no wrap inside a state.
- ack, load, busy, d, grant_id are all registered outputs (no combinational path from req).

Optional Feature:
UART_ARB_FIXED_PRIO_EN: when defined, the winner is the lowest-index set req bit (requester 0 highest priority) and the rr pointer is unused; grant_id still reports the winner. When undefined, round-robin as described above.

Test Plan:
Setup: CLKS_PER_BIT=4, FRAME_BITS=10, LOAD_LAT=2, GAP_CLKS=2 -> T=42, spacing=46.
1. Reset, then req=4'b0001, din[7:0]=8'hA5 -> next cycle load=1, ack=4'b0001, d=8'hA5, grant_id=0; busy high 45 cycles; txd frame of 0xA5 LSB-first at 4 clk/bit.
2. req=4'b1111 held, distinct bytes 8'h11,8'h22,8'h33,8'h44 -> grants in order 0,1,2,3,0; load pulses exactly 46 cycles apart; each ack one cycle.
3. req[2] pulsed during WAIT of another grant, low again before IDLE -> no ack[2], no extra load.
4. Async reset asserted mid-WAIT -> load/ack/busy/d go 0 immediately without clock; after release, req=4'b0100 -> requester 2 granted one cycle after sampling, grant_id=2.
5. Define UART_ARB_FIXED_PRIO_EN, req=4'b1010 held -> requester 1 granted on every frame, requester 3 never.
6. GAP_CLKS=0 rebuild, req=4'b0001 held -> load spacing 44 cycles, no GAP state entered.
